// File: rtl/servo_pkg.sv
// Shared definitions for the servo ramp controller: state codes, width, reset period, clamp helper.
package servo_pkg;

  localparam int unsigned PW_W = 16;

  localparam logic [PW_W-1:0] ARR_DEFAULT = 16'd19999;

  // Channel states, kept as plain constants for legacy tool compatibility.
  localparam logic [1:0] StDisabled = 2'd0;
  localparam logic [1:0] StIdle     = 2'd1;
  localparam logic [1:0] StRamp     = 2'd2;

  // Limit a requested width to [lo, hi], then never beyond the period value lim.
  function automatic logic [PW_W-1:0] clamp_pw(input logic [PW_W-1:0] t,
                                               input logic [PW_W-1:0] lo,
                                               input logic [PW_W-1:0] hi,
                                               input logic [PW_W-1:0] lim);
    logic [PW_W-1:0] r;
    r = t;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    if (r > lim) r = lim;
    return r;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Period counter: fcnt runs 0..arr and wraps; frame_tick marks the last cycle of each period.
module servo_frame_timer
  import servo_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic [PW_W-1:0] arr_i,
  output logic            frame_tick_o
);

  logic [PW_W-1:0] fcnt_q;

  // Held at zero while stopped so the first running cycle starts a fresh period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fcnt_q <= '0;
    end else if (!run_i || (fcnt_q == arr_i)) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  // Period boundary indication.
  always_comb begin
    frame_tick_o = run_i && (fcnt_q == arr_i);
  end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Servo PWM channel sequencer: accepts target commands, slews cvr per frame, updates only at
// period boundaries. Optional watchdog enabled by defining SERVO_WDOG_EN.
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned PW_MIN         = 1000,
  parameter int unsigned PW_MAX         = 2000,
  parameter int unsigned PW_DEFAULT     = 1500,
  parameter int unsigned TIMEOUT_FRAMES = 50
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [PW_W-1:0] arr_cfg_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [PW_W-1:0] cmd_target_i,
  input  logic [PW_W-1:0] cmd_step_i,
  output logic [PW_W-1:0] cvr_o,
  output logic [PW_W-1:0] arr_o,
  output logic            pwm_nrst_o,
  output logic            frame_tick_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            wdog_trip_o
);

  localparam logic [PW_W-1:0] PwMin = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0] PwMax = PW_W'(PW_MAX);
  localparam logic [PW_W-1:0] PwDef = PW_W'(PW_DEFAULT);

  logic [1:0]      state_q, state_d;
  logic [PW_W-1:0] cvr_q, cvr_d;
  logic [PW_W-1:0] arr_q, arr_d;
  logic [PW_W-1:0] tgt_q, tgt_d;
  logic [PW_W-1:0] stp_q, stp_d;
  logic            nrst_q, nrst_d;
  logic            done_q, done_d;
  logic            frame_tick;
  logic            accept;
  logic            wdog_trip;
  logic [PW_W:0]   diff;

  servo_frame_timer u_frame_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .run_i        (state_q != StDisabled),
    .arr_i        (arr_q),
    .frame_tick_o (frame_tick)
  );

`ifdef SERVO_WDOG_EN
  localparam logic [PW_W-1:0] WdLimit = PW_W'(TIMEOUT_FRAMES - 1);
  logic            trip_q, trip_d;
  logic [PW_W-1:0] wcnt_q, wcnt_d;
  assign wdog_trip = trip_q;
`else
  assign wdog_trip = 1'b0;
`endif

  assign accept = (state_q == StIdle) && cmd_valid_i;

  // Next-state: enable handling, command accept, per-frame slew, optional watchdog override.
  always_comb begin
    state_d = state_q;
    cvr_d   = cvr_q;
    arr_d   = arr_q;
    tgt_d   = tgt_q;
    stp_d   = stp_q;
    nrst_d  = nrst_q;
    done_d  = 1'b0;
    // 17-bit distance so neither direction can wrap.
    diff    = (tgt_q >= cvr_q) ? ({1'b0, tgt_q} - {1'b0, cvr_q})
                               : ({1'b0, cvr_q} - {1'b0, tgt_q});
`ifdef SERVO_WDOG_EN
    trip_d  = trip_q;
    wcnt_d  = wcnt_q;
`endif
    if (!en_i) begin
      state_d = StDisabled;
      nrst_d  = 1'b0;
      cvr_d   = PwDef;
`ifdef SERVO_WDOG_EN
      trip_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        StDisabled: begin
          // A tripped channel stays off until en is cycled low.
          if (!wdog_trip) begin
            state_d = StIdle;
            arr_d   = arr_cfg_i;
            cvr_d   = PwDef;
            nrst_d  = 1'b1;
`ifdef SERVO_WDOG_EN
            wcnt_d  = '0;
`endif
          end
        end
        StIdle: begin
          if (accept) begin
            tgt_d   = clamp_pw(cmd_target_i, PwMin, PwMax, arr_q);
            stp_d   = cmd_step_i;
            state_d = StRamp;
          end
        end
        StRamp: begin
          if (frame_tick) begin
            if ((stp_q == '0) || (diff <= {1'b0, stp_q})) begin
              cvr_d   = tgt_q;
              done_d  = 1'b1;
              state_d = StIdle;
            end else if (tgt_q > cvr_q) begin
              cvr_d = cvr_q + stp_q;
            end else begin
              cvr_d = cvr_q - stp_q;
            end
          end
        end
        default: begin
          state_d = StDisabled;
          nrst_d  = 1'b0;
          cvr_d   = PwDef;
        end
      endcase
`ifdef SERVO_WDOG_EN
      // Timeout takes priority over a ramp finishing on the same frame.
      if (state_q != StDisabled) begin
        if (accept) begin
          wcnt_d = '0;
        end else if (frame_tick) begin
          if (wcnt_q >= WdLimit) begin
            trip_d  = 1'b1;
            nrst_d  = 1'b0;
            cvr_d   = PwDef;
            done_d  = 1'b0;
            state_d = StDisabled;
          end else begin
            wcnt_d = wcnt_q + 16'd1;
          end
        end
      end
`endif
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StDisabled;
      cvr_q   <= PwDef;
      arr_q   <= ARR_DEFAULT;
      tgt_q   <= PwDef;
      stp_q   <= '0;
      nrst_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERVO_WDOG_EN
      trip_q  <= 1'b0;
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cvr_q   <= cvr_d;
      arr_q   <= arr_d;
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
      nrst_q  <= nrst_d;
      done_q  <= done_d;
`ifdef SERVO_WDOG_EN
      trip_q  <= trip_d;
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  // Output mapping.
  always_comb begin
    cmd_ready_o  = (state_q == StIdle);
    busy_o       = (state_q == StRamp);
    cvr_o        = cvr_q;
    arr_o        = arr_q;
    pwm_nrst_o   = nrst_q;
    done_o       = done_q;
    frame_tick_o = frame_tick;
    wdog_trip_o  = wdog_trip;
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Self-checking bench for servo_ramp_ctrl: directed steps plus random traffic against a frame-level model.
module tb_servo_ramp_ctrl;

  localparam int PMIN = 10;
  localparam int PMAX = 90;
  localparam int PDEF = 50;
  localparam int TOUT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] arr_cfg = 16'd99;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_target = '0;
  logic [15:0] cmd_step = '0;
  logic [15:0] cvr, arr;
  logic        pwm_nrst, frame_tick, busy, done, wdog_trip;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: channel on/off, ramping flag, enabled-cycle count since enable.
  int m_on = 0, m_ramp = 0, m_cvr = PDEF, m_arr = 19999, m_tgt = 0, m_stp = 0;
  int m_done = 0, m_trip = 0, m_cyc = 0, m_wd = 0;

  servo_ramp_ctrl #(
    .PW_MIN         (PMIN),
    .PW_MAX         (PMAX),
    .PW_DEFAULT     (PDEF),
    .TIMEOUT_FRAMES (TOUT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .arr_cfg_i    (arr_cfg),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_target_i (cmd_target),
    .cmd_step_i   (cmd_step),
    .cvr_o        (cvr),
    .arr_o        (arr),
    .pwm_nrst_o   (pwm_nrst),
    .frame_tick_o (frame_tick),
    .busy_o       (busy),
    .done_o       (done),
    .wdog_trip_o  (wdog_trip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_tick();
    return (m_on != 0 && (m_cyc % (m_arr + 1)) == m_arr) ? 1 : 0;
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_step();
    int tick, acc, trip, d, t;
    if (rst) begin
      m_on = 0; m_ramp = 0; m_cvr = PDEF; m_arr = 19999; m_done = 0; m_trip = 0;
      m_cyc = 0; m_wd = 0;
    end else if (!en) begin
      m_on = 0; m_ramp = 0; m_cvr = PDEF; m_done = 0; m_trip = 0; m_cyc = 0;
    end else if (m_on == 0) begin
      m_done = 0;
      if (m_trip == 0) begin
        m_on = 1; m_arr = int'(arr_cfg); m_cvr = PDEF; m_cyc = 0; m_wd = 0;
      end
    end else begin
      tick = m_tick();
      acc = (m_ramp == 0 && cmd_valid) ? 1 : 0;
      m_done = 0;
      trip = 0;
`ifdef SERVO_WDOG_EN
      if (acc != 0) m_wd = 0;
      else if (tick != 0) begin
        m_wd++;
        if (m_wd >= TOUT) trip = 1;
      end
`endif
      if (trip != 0) begin
        m_on = 0; m_ramp = 0; m_cvr = PDEF; m_trip = 1; m_cyc = 0;
      end else begin
        if (m_ramp != 0 && tick != 0) begin
          d = (m_tgt > m_cvr) ? m_tgt - m_cvr : m_cvr - m_tgt;
          if (m_stp == 0 || d <= m_stp) begin
            m_cvr = m_tgt; m_done = 1; m_ramp = 0;
          end else begin
            m_cvr = (m_tgt > m_cvr) ? m_cvr + m_stp : m_cvr - m_stp;
          end
        end else if (acc != 0) begin
          t = int'(cmd_target);
          if (t > PMAX) t = PMAX;
          if (t < PMIN) t = PMIN;
          if (t > m_arr) t = m_arr;
          m_tgt = t; m_stp = int'(cmd_step); m_ramp = 1;
        end
        m_cyc++;
      end
    end
  endtask

  task automatic check_all();
    chk("cvr", 32'(cvr), 32'(m_cvr));
    chk("arr", 32'(arr), 32'(m_arr));
    chk("pwm_nrst", 32'(pwm_nrst), 32'(m_on));
    chk("cmd_ready", 32'(cmd_ready), 32'((m_on != 0 && m_ramp == 0) ? 1 : 0));
    chk("busy", 32'(busy), 32'(m_ramp));
    chk("done", 32'(done), 32'(m_done));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick()));
    chk("wdog_trip", 32'(wdog_trip), 32'(m_trip));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send_cmd(input int tgt, input int stp);
    cmd_valid = 1'b1; cmd_target = 16'(tgt); cmd_step = 16'(stp);
    cyc();
    cmd_valid = 1'b0;
  endtask

  // Advance to the cycle just after the next frame boundary edge.
  task automatic wait_tick();
    int n = 0;
    while (frame_tick !== 1'b1 && n < 400) begin
      cyc();
      n++;
    end
    chk("tick_timeout", 32'(frame_tick), 32'd1);
    cyc();
  endtask

  task automatic reenable();
    en = 1'b0; cyc();
    en = 1'b1; cyc();
  endtask

  initial begin
    // 1: reset state, enable, period length
    rst = 1'b1; en = 1'b0;
    cyc(); cyc();
    chk("rst_cvr", 32'(cvr), 32'(PDEF));
    chk("rst_arr", 32'(arr), 32'd19999);
    chk("rst_nrst", 32'(pwm_nrst), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0; cyc();
    chk("dis_nrst", 32'(pwm_nrst), 32'd0);
    en = 1'b1; arr_cfg = 16'd99; cyc();
    chk("en_arr", 32'(arr), 32'd99);
    chk("en_nrst", 32'(pwm_nrst), 32'd1);
    arr_cfg = 16'd40;
    for (int i = 0; i < 99; i++) cyc();
    chk("tick_99", 32'(frame_tick), 32'd1);
    cyc();
    chk("tick_100", 32'(frame_tick), 32'd0);
    for (int i = 0; i < 99; i++) cyc();
    chk("tick_199", 32'(frame_tick), 32'd1);
    chk("arr_held", 32'(arr), 32'd99);
    arr_cfg = 16'd99;
`ifndef SERVO_WDOG_EN
    // 2: stepped ramp 50 -> 80
    reenable();
    send_cmd(80, 10);
    chk("r2_busy", 32'(busy), 32'd1);
    wait_tick(); chk("r2_cvr60", 32'(cvr), 32'd60);
    wait_tick(); chk("r2_cvr70", 32'(cvr), 32'd70);
    wait_tick(); chk("r2_cvr80", 32'(cvr), 32'd80);
    chk("r2_done", 32'(done), 32'd1);
    chk("r2_busy_lo", 32'(busy), 32'd0);
    cyc(); chk("r2_done_pulse", 32'(done), 32'd0);
    // 3: jump and clamping
    reenable();
    send_cmd(85, 0); wait_tick(); chk("r3_jump", 32'(cvr), 32'd85);
    send_cmd(200, 0); wait_tick(); chk("r3_clamp_hi", 32'(cvr), 32'd90);
    send_cmd(3, 0); wait_tick(); chk("r3_clamp_lo", 32'(cvr), 32'd10);
    // 4: no overshoot, command refused during ramp
    reenable();
    send_cmd(57, 10);
    cmd_valid = 1'b1; cmd_target = 16'd20; cmd_step = 16'd0;
    chk("r4_not_ready", 32'(cmd_ready), 32'd0);
    cyc(); cmd_valid = 1'b0;
    wait_tick(); chk("r4_cvr57", 32'(cvr), 32'd57);
    chk("r4_done", 32'(done), 32'd1);
    // 5: enable drop and reset mid-ramp
    send_cmd(80, 10); wait_tick(); chk("r5_cvr67", 32'(cvr), 32'd67);
    en = 1'b0; cyc();
    chk("r5_nrst", 32'(pwm_nrst), 32'd0);
    chk("r5_cvr", 32'(cvr), 32'(PDEF));
    chk("r5_no_done", 32'(done), 32'd0);
    chk("r5_busy", 32'(busy), 32'd0);
    en = 1'b1; cyc();
    send_cmd(80, 10); wait_tick();
    rst = 1'b1; cyc();
    chk("r5_rst_cvr", 32'(cvr), 32'(PDEF));
    chk("r5_rst_arr", 32'(arr), 32'd19999);
    chk("r5_rst_nrst", 32'(pwm_nrst), 32'd0);
    chk("r5_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; cyc();
`endif
    // 6: watchdog behaviour across three idle frames
    reenable();
    wait_tick(); wait_tick(); wait_tick();
`ifdef SERVO_WDOG_EN
    chk("r6_trip", 32'(wdog_trip), 32'd1);
    chk("r6_nrst", 32'(pwm_nrst), 32'd0);
`else
    chk("r6_trip", 32'(wdog_trip), 32'd0);
    chk("r6_nrst", 32'(pwm_nrst), 32'd1);
`endif
    en = 1'b0; cyc();
    chk("r6_trip_clr", 32'(wdog_trip), 32'd0);
    // Random traffic
    en = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      en = en ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 9) == 0);
      arr_cfg = 16'($urandom_range(5, 60));
      cmd_valid = ($urandom_range(0, 5) == 0);
      cmd_target = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 130));
      cmd_step = ($urandom_range(0, 9) == 0) ? 16'hFFF0 : 16'($urandom_range(0, 25));
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
